// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared types and constants for the baccarat dealer controller
//   state_e   : 4-bit sequencer state encoding
//   CARD_*    : raw card code landmarks (0 = no card, 10 and above score zero)
//   NATURAL_MIN / STAND_MIN : two-card total thresholds
//   sat_inc8  : 8-bit increment that sticks at 255
package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    P1     = 4'd1,
    D1     = 4'd2,
    P2     = 4'd3,
    D2     = 4'd4,
    CHK    = 4'd5,
    P3     = 4'd6,
    BCHK   = 4'd7,
    D3     = 4'd8,
    RESULT = 4'd9,
    DONE   = 4'd10
  } state_e;

  localparam logic [3:0] CARD_NONE   = 4'd0;
  localparam logic [3:0] CARD_TEN    = 4'd10;
  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] STAND_MIN   = 4'd6;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/baccarat_dealer_fsm_banker_draw.sv
// rtl/baccarat_dealer_fsm_banker_draw.sv - dealer third-card drawing rule
//   dscore : dealer two-card total (0-9)
//   pcard3 : raw player third-card code (face cards and tens count as zero)
//   draw   : 1 when the dealer must take a third card
module banker_draw
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = (pcard3 >= CARD_TEN) ? CARD_NONE : pcard3;
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_dealer_fsm.sv
// rtl/baccarat_dealer_fsm.sv - baccarat round sequencer, outcome flags and tallies
//   slow_clock, reset     : clock and synchronous active-high reset
//   step                  : advance one state per cycle while high
//   pscore, dscore        : hand totals from the external scorehand blocks
//   pcard3                : raw player third-card code
//   clr_cards, load_*     : card register clear/load strobes (combinational)
//   player_win/dealer_win : registered outcome, both high on a tie
//   round_done            : one-cycle pulse after entering DONE
//   player_wins/dealer_wins/ties : saturating round tallies
module baccarat_dealer_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       clr_cards,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       round_done,
  output logic [7:0] player_wins,
  output logic [7:0] dealer_wins,
  output logic [7:0] ties
);

  state_e     state_q, state_d;
  logic       player_win_q, player_win_d;
  logic       dealer_win_q, dealer_win_d;
  logic       round_done_q, round_done_d;
  logic [7:0] player_wins_q, player_wins_d;
  logic [7:0] dealer_wins_q, dealer_wins_d;
  logic [7:0] ties_q, ties_d;
  logic       bank_draw;
  logic       go;

  banker_draw u_banker_draw (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (bank_draw)
  );

  // Reset masks the strobes so a reset+step cycle never clears or loads cards.
  assign go          = step & ~reset;
  assign clr_cards   = go & ((state_q == IDLE) || (state_q == DONE));
  assign load_pcard1 = go & (state_q == P1);
  assign load_pcard2 = go & (state_q == P2);
  assign load_pcard3 = go & (state_q == P3);
  assign load_dcard1 = go & (state_q == D1);
  assign load_dcard2 = go & (state_q == D2);
  assign load_dcard3 = go & (state_q == D3);

  assign player_win  = player_win_q;
  assign dealer_win  = dealer_win_q;
  assign round_done  = round_done_q;
  assign player_wins = player_wins_q;
  assign dealer_wins = dealer_wins_q;
  assign ties        = ties_q;

  always_comb begin
    state_d       = state_q;
    player_win_d  = player_win_q;
    dealer_win_d  = dealer_win_q;
    round_done_d  = 1'b0;
    player_wins_d = player_wins_q;
    dealer_wins_d = dealer_wins_q;
    ties_d        = ties_q;
    if (step) begin
      case (state_q)
        IDLE, DONE: begin
          state_d      = P1;
          player_win_d = 1'b0;
          dealer_win_d = 1'b0;
        end
        P1: state_d = D1;
        D1: state_d = P2;
        P2: state_d = D2;
        D2: state_d = CHK;
        CHK: begin
          if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) state_d = RESULT;
          else if (pscore < STAND_MIN)                            state_d = P3;
          // Player stands on 6-7: dealer draws on 0-5 without the tableau.
          else if (dscore < STAND_MIN)                            state_d = D3;
          else                                                    state_d = RESULT;
        end
        P3:   state_d = BCHK;
        BCHK: state_d = bank_draw ? D3 : RESULT;
        D3:   state_d = RESULT;
        RESULT: begin
          state_d      = DONE;
          round_done_d = 1'b1;
          player_win_d = (pscore >= dscore);
          dealer_win_d = (dscore >= pscore);
          if (pscore == dscore)     ties_d        = sat_inc8(ties_q);
          else if (pscore > dscore) player_wins_d = sat_inc8(player_wins_q);
          else                      dealer_wins_d = sat_inc8(dealer_wins_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q       <= IDLE;
      player_win_q  <= 1'b0;
      dealer_win_q  <= 1'b0;
      round_done_q  <= 1'b0;
      player_wins_q <= 8'd0;
      dealer_wins_q <= 8'd0;
      ties_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      player_win_q  <= player_win_d;
      dealer_win_q  <= dealer_win_d;
      round_done_q  <= round_done_d;
      player_wins_q <= player_wins_d;
      dealer_wins_q <= dealer_wins_d;
      ties_q        <= ties_d;
    end
  end

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// tb/tb_baccarat_dealer_fsm.sv - self-checking bench for baccarat_dealer_fsm
module tb_baccarat_dealer_fsm;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic       clr_cards, load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win, dealer_win, round_done;
  logic [7:0] player_wins, dealer_wins, ties;

  baccarat_dealer_fsm dut (
    .slow_clock  (slow_clock),
    .reset       (reset),
    .step        (step),
    .pscore      (pscore),
    .dscore      (dscore),
    .pcard3      (pcard3),
    .clr_cards   (clr_cards),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .player_win  (player_win),
    .dealer_win  (dealer_win),
    .round_done  (round_done),
    .player_wins (player_wins),
    .dealer_wins (dealer_wins),
    .ties        (ties)
  );

  always #5 slow_clock = ~slow_clock;

  // Card source and card registers, with combinational scorehand.
  logic [3:0] pc1s, pc2s, pc3s, dc1s, dc2s, dc3s;
  logic [3:0] p1r = 0, p2r = 0, p3r = 0, d1r = 0, d2r = 0, d3r = 0;

  function automatic int pv(input logic [3:0] c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction

  always @(posedge slow_clock) begin
    if (clr_cards) begin
      p1r <= 0; p2r <= 0; p3r <= 0; d1r <= 0; d2r <= 0; d3r <= 0;
    end
    if (load_pcard1) p1r <= pc1s;
    if (load_pcard2) p2r <= pc2s;
    if (load_pcard3) p3r <= pc3s;
    if (load_dcard1) d1r <= dc1s;
    if (load_dcard2) d2r <= dc2s;
    if (load_dcard3) d3r <= dc3s;
  end

  assign pscore = 4'((pv(p1r) + pv(p2r) + pv(p3r)) % 10);
  assign dscore = 4'((pv(d1r) + pv(d2r) + pv(d3r)) % 10);
  assign pcard3 = p3r;

  int n_cmp = 0;
  int n_bad = 0;
  int m_pw = 0, m_dw = 0, m_tie = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive step, sample {round_done, clr, p1, d1, p2, d2, p3, d3} mid-cycle.
  task automatic tick(input logic s, output logic [7:0] v);
    step = s;
    @(negedge slow_clock);
    v = {round_done, clr_cards, load_pcard1, load_dcard1, load_pcard2,
         load_dcard2, load_pcard3, load_dcard3};
    @(posedge slow_clock);
    #1;
  endtask

  // Dealer drawing tableau after a player third card: bit v set means draw.
  function automatic logic dealer_takes(input int dt, input int v);
    logic [9:0] m;
    case (dt)
      0, 1, 2: m = 10'h3FF;
      3:       m = 10'h2FF;
      4:       m = 10'h0FC;
      5:       m = 10'h0F0;
      6:       m = 10'h0C0;
      default: m = 10'h000;
    endcase
    return m[v];
  endfunction

  task automatic play_round(input int a, input int b, input int c,
                            input int d, input int e, input int f,
                            input int stall_pct);
    int pt2, dt2, pt, dt;
    logic natural, pdraw, ddraw;
    logic [7:0] q[$];
    logic [7:0] v;
    pc1s = 4'(a); pc2s = 4'(b); pc3s = 4'(c);
    dc1s = 4'(d); dc2s = 4'(e); dc3s = 4'(f);
    pt2 = (pv(4'(a)) + pv(4'(b))) % 10;
    dt2 = (pv(4'(d)) + pv(4'(e))) % 10;
    natural = (pt2 >= 8) || (dt2 >= 8);
    pdraw = !natural && (pt2 <= 5);
    if (natural)    ddraw = 1'b0;
    else if (pdraw) ddraw = dealer_takes(dt2, pv(4'(c)));
    else            ddraw = (dt2 <= 5);
    pt = pdraw ? (pt2 + pv(4'(c))) % 10 : pt2;
    dt = ddraw ? (dt2 + pv(4'(f))) % 10 : dt2;

    q = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h00};
    if (pdraw) begin q.push_back(8'h02); q.push_back(8'h00); end
    if (ddraw) q.push_back(8'h01);
    q.push_back(8'h00);

    for (int i = 0; i < q.size(); i++) begin
      if (int'($urandom_range(0, 99)) < stall_pct) begin
        tick(1'b0, v);
        chk($sformatf("stall%0d", i), int'(v), 0);
      end
      tick(1'b1, v);
      chk($sformatf("seq%0d", i), int'(v), int'(q[i]));
      if (i == 1) chk("flags_cleared", int'({player_win, dealer_win}), 0);
    end

    if (pt == dt)     m_tie = (m_tie < 255) ? m_tie + 1 : 255;
    else if (pt > dt) m_pw  = (m_pw  < 255) ? m_pw  + 1 : 255;
    else              m_dw  = (m_dw  < 255) ? m_dw  + 1 : 255;

    tick(1'b0, v);
    chk("round_done_hi", int'(v), 8'h80);
    chk("player_win", int'(player_win), int'(pt >= dt));
    chk("dealer_win", int'(dealer_win), int'(dt >= pt));
    chk("player_wins", int'(player_wins), m_pw);
    chk("dealer_wins", int'(dealer_wins), m_dw);
    chk("ties", int'(ties), m_tie);
    tick(1'b0, v);
    chk("round_done_lo", int'(v), 0);
    chk("flags_held", int'({player_win, dealer_win}), int'({pt >= dt, dt >= pt}));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_flags"}, int'({player_win, dealer_win, round_done}), 0);
    chk({tag, "_tallies"}, int'({player_wins, dealer_wins, ties}), 0);
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1;
    tick(1'b1, v);
    chk("reset_strobes", int'(v), 0);
    tick(1'b0, v);
    reset = 1'b0;
    check_reset_state("reset");
    tick(1'b0, v);
    chk("idle_no_step", int'(v), 0);

    // Directed rounds
    play_round(4, 4, 5, 2, 3, 5, 0);     // natural 8 vs 5
    chk("t1_pw", int'(player_win), 1);
    play_round(2, 3, 9, 3, 4, 6, 0);     // player 4, dealer stands on 7
    chk("t2_dw", int'(dealer_win), 1);
    play_round(1, 2, 6, 3, 3, 13, 0);    // player 9, dealer draws K on v=6
    play_round(2, 2, 13, 1, 2, 5, 0);    // v=0 with dealer 3: draws
    play_round(10, 6, 4, 2, 3, 2, 0);    // player stands, dealer straight to D3
    chk("t4_dw", int'({player_win, dealer_win}), 1);
    play_round(3, 4, 1, 10, 7, 1, 0);    // tie 7-7
    chk("t5_tie", int'({player_win, dealer_win}), 3);

    // Stall in P2, then reset from BCHK
    pc1s = 2; pc2s = 1; pc3s = 5; dc1s = 3; dc2s = 3; dc3s = 1;
    tick(1'b1, v); chk("rs_clr", int'(v), 8'h40);
    tick(1'b1, v); chk("rs_p1", int'(v), 8'h20);
    tick(1'b1, v); chk("rs_d1", int'(v), 8'h10);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, v);
      chk($sformatf("rs_stall%0d", i), int'(v), 0);
    end
    tick(1'b1, v); chk("rs_p2", int'(v), 8'h08);
    tick(1'b1, v); chk("rs_d2", int'(v), 8'h04);
    tick(1'b1, v); chk("rs_chk", int'(v), 8'h00);
    tick(1'b1, v); chk("rs_p3", int'(v), 8'h02);
    reset = 1'b1;
    tick(1'b1, v); chk("rs_reset_step", int'(v), 0);
    reset = 1'b0;
    m_pw = 0; m_dw = 0; m_tie = 0;
    tick(1'b0, v); chk("rs_idle", int'(v), 0);
    check_reset_state("rs");
    tick(1'b1, v); chk("rs_clr_after", int'(v), 8'h40);
    tick(1'b1, v); chk("rs_p1_after", int'(v), 8'h20);
    reset = 1'b1;
    tick(1'b0, v);
    reset = 1'b0;

    // Random rounds with random stalls
    for (int r = 0; r < 150; r++)
      play_round(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                 int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                 int'($urandom_range(1, 13)), int'($urandom_range(1, 13)), 20);

    // Drive ties past saturation
    for (int r = 0; r < 256; r++) play_round(3, 4, 1, 10, 7, 1, 0);
    chk("ties_sat", int'(ties), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
